serial_tx_sched: RTL
====================

Name: serial_tx_sched

Overview:
Transmit scheduler for the serial link. It shares one 11-bit serial frame transmitter between two requesters using round-robin arbitration, and latches the granted byte into a frame. It then sequences the frame onto the line with a bit timer and a bit-index counter, and pulses char_complete when the frame ends. It sits between the two byte producers and the tx pin.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal values >= 2.
PARITY_ODD, 0, 0 = even parity bit, 1 = odd parity bit.

Ports:
clk  input  1  system clock; all logic is on posedge.
reset  input  1  synchronous, active-high reset.
req  input  2  per-requester transmit request; held until that requester's ack.
data0  input  8  byte from requester 0; must be stable while req[0] is high.
data1  input  8  byte from requester 1; must be stable while req[1] is high.
ack  output  2  one-hot, one-cycle grant pulse; the byte is captured on that edge.
tx  output  1  serial line; idles high.
busy  output  1  high from the grant cycle through the DONE cycle.
bit_idx  output  4  index of the frame bit currently driven, 0..10.
char_complete  output  1  one-cycle pulse after the stop bit finishes.

Behaviour:
- Reset values: tx=1, busy=0, ack=2'b00, char_complete=0, bit_idx=0, state=IDLE, round-robin pointer rr=0.
- Frame layout, LSB first: bit0 = start (0), bits1-8 = data[0..7], bit9 = parity, bit10 = stop (1).
- Parity: even parity is ^data; odd parity is ~^data.
- Registered FSM states: IDLE, SEND, DONE.
- IDLE, req==00: stay in IDLE with tx=1.
- IDLE, any req bit set: grant g.
  - If exactly one req bit is set, g is that requester.
  - If both are set, g = rr.
  - On that edge: ack[g]=1 for one cycle, latch the frame from data_g, bit_idx=0, timer=0, busy=1, next state = SEND.
  - tx=0 (start bit) in the same cycle ack is high.
- SEND:
  - tx = frame[bit_idx].
  - The timer counts 0..CLKS_PER_BIT-1.
  - At timer terminal with bit_idx<10: bit_idx+1, timer=0.
  - At timer terminal with bit_idx==10: next state = DONE.
  - Each bit is exactly CLKS_PER_BIT cycles; the frame is 11*CLKS_PER_BIT cycles.
- DONE (one cycle): char_complete=1, tx=1, busy=1, rr = ~g (the other requester gets priority), bit_idx=0, next state = IDLE.
- Minimum gap between stop-bit end and the next start bit is 2 cycles (DONE, then IDLE).
- req edges arriving while busy are ignored; they are only sampled in IDLE.
- A requester that drops req before its ack forfeits the slot. No frame is sent for it.
- The ack vector is never 2'b11.
- Reset mid-frame:
  - Abort the frame; tx=1 and busy=0 from the next cycle.
  - No char_complete is issued.
  - rr returns to 0 and the latched frame is discarded.
- bit_idx never exceeds 10; there is no wrap path other than DONE to 0.
- Timer width is $clog2(CLKS_PER_BIT).

Decomposition:
- Package serial_pkg holds:
  - FRAME_BITS = 11
  - LAST_BIT_IDX = 4'd10
  - typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t
  - function frame_build(data, parity_odd), returning an 11-bit frame
- Sub-module serial_bit_timer (parameter CLKS_PER_BIT; ports clk, reset, clear, tick):
  - Free counter with synchronous clear.
  - tick pulses at terminal count.
  - The scheduler instantiates one.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
- Reset held 3 cycles, then req=00 for 10 cycles -> tx=1, busy=0, ack=00, char_complete=0 throughout.
- req=01, data0=8'hA5 -> ack=01 for one cycle; tx each 4 cycles = 0,1,0,1,0,0,1,0,1,0,1 (parity 0); char_complete pulses exactly 44 cycles after the ack cycle; busy falls the cycle after the pulse.
- req=11 held, data0=8'h01, data1=8'h80 -> ack order 01,10,01,10; bit 9 is 1 for both frames; start bits are 2 cycles after the preceding stop end.
- PARITY_ODD=1, req=10, data1=8'h00 -> tx bit 9 = 1, bits 1-8 all 0, stop = 1.
- req=01 frame in progress, reset asserted while bit_idx=5 -> next cycle tx=1, busy=0, bit_idx=0; no char_complete; after release with req=11, ack=01 (rr cleared).
- req=11, req[1] dropped during requester 0's frame -> after DONE, ack stays 00, tx=1, state stays IDLE.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared frame constants, FSM state type and frame builder for the serial transmitter
package serial_pkg;

    localparam int FRAME_BITS = 11;
    localparam logic [3:0] LAST_BIT_IDX = 4'd10;

    typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;

    // Frame is LSB first: start(0), data[0..7], parity, stop(1).
    function automatic logic [FRAME_BITS-1:0] frame_build(input logic [7:0] data, input logic parity_odd);
        logic par;
        par = parity_odd ? ~^data : ^data;
        return {1'b1, par, data, 1'b0};
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// rtl/serial_bit_timer.sv - free-running bit period counter with synchronous clear and terminal tick
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TERM = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    assign tick = (cnt == TERM);

    // Count 0..CLKS_PER_BIT-1 and wrap; clear holds the count at zero outside a frame.
    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/serial_tx_sched.sv
// rtl/serial_tx_sched.sv - round-robin arbiter and frame sequencer sharing one serial transmitter
module serial_tx_sched
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] ack,
    output logic       tx,
    output logic       busy,
    output logic [3:0] bit_idx,
    output logic       char_complete
);

    tx_state_t             state;
    logic [FRAME_BITS-1:0] frame;
    logic                  gnt;
    logic                  rr;
    logic                  g_sel;
    logic                  tick;
    logic                  timer_clear;

    // A lone requester always wins; a tie goes to the round-robin pointer.
    assign g_sel = (req == 2'b01) ? 1'b0 :
                   (req == 2'b10) ? 1'b1 : rr;

    // The timer only runs while a frame is on the line, so each bit starts from zero.
    assign timer_clear = (state != SEND);

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .reset(reset),
        .clear(timer_clear),
        .tick (tick)
    );

    // Arbitration, frame latch and bit sequencing; all outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            frame         <= '0;
            gnt           <= 1'b0;
            rr            <= 1'b0;
            ack           <= 2'b00;
            tx            <= 1'b1;
            busy          <= 1'b0;
            bit_idx       <= 4'd0;
            char_complete <= 1'b0;
        end else begin
            ack           <= 2'b00;
            char_complete <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    bit_idx <= 4'd0;
                    if (req != 2'b00) begin
                        gnt   <= g_sel;
                        ack   <= g_sel ? 2'b10 : 2'b01;
                        frame <= frame_build(g_sel ? data1 : data0, PARITY_ODD != 0);
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT_IDX) begin
                            state         <= DONE;
                            tx            <= 1'b1;
                            bit_idx       <= 4'd0;
                            char_complete <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            tx      <= frame[bit_idx + 4'd1];
                        end
                    end
                end
                DONE: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    rr    <= ~gnt;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
